// File: rtl/replay_sample_fifo.sv
// Single-clock sample FIFO with a replay mark: entries popped after i_mark stay protected and can be re-read via i_rewind.
// Optional sticky overflow/underflow flags are enabled by defining REPLAY_SAMPLE_FIFO_ERR_FLAG_EN.
module replay_sample_fifo #(
  parameter int FIFO_WIDTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int RD_LAT         = 2,
  parameter int AFULL_THRESH   = (2**FIFO_DEPTH_BIT) - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_mark,
  input  logic                    i_mark_clr,
  input  logic                    i_rewind,
  input  logic                    i_push,
  input  logic [FIFO_WIDTH-1:0]   i_rear,
  input  logic                    i_pop,
  output logic [FIFO_WIDTH-1:0]   o_front,
  output logic                    o_vld,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_afull,
  output logic [FIFO_DEPTH_BIT:0] o_count,
  output logic                    o_ovf,
  output logic                    o_udf
);

  localparam int DEPTH = 2**FIFO_DEPTH_BIT;
  localparam int PW    = FIFO_DEPTH_BIT + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [FIFO_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         mptr;
  logic [PW-1:0]         base;
  logic [PW-1:0]         occ;
  logic                  mark_active;
  logic                  rewind_eff;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  mark_set;
  logic                  mark_drop;
  logic                  pipe_clr;
  logic [RD_LAT-1:0]     vld_pipe;
  logic [FIFO_WIDTH-1:0] data_pipe [RD_LAT];

  // While marked, occupancy counts from the mark so replayable entries are never overwritten.
  assign base    = mark_active ? mptr : rptr;
  assign occ     = wptr - base;
  assign o_full  = (occ == DEPTH_P);
  assign o_afull = (occ >= AFULL_P);
  assign o_empty = (wptr == rptr);
  assign o_count = wptr - rptr;

  assign rewind_eff = i_rewind & mark_active & ~i_flush;
  assign push_ok    = i_push & ~o_full & ~i_flush;
  assign pop_ok     = i_pop & ~o_empty & ~i_rewind & ~i_flush;
  assign mark_set   = i_mark & ~rewind_eff & ~i_flush;
  assign mark_drop  = i_mark_clr & ~i_mark & ~rewind_eff & ~i_flush;
  assign pipe_clr   = i_flush | rewind_eff;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[FIFO_DEPTH_BIT-1:0]] <= i_rear;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      mptr        <= '0;
      mark_active <= 1'b0;
    end else if (i_flush) begin
      wptr        <= '0;
      rptr        <= '0;
      mptr        <= '0;
      mark_active <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + ONE_P;
      end
      if (rewind_eff) begin
        rptr <= mptr;
      end else if (pop_ok) begin
        rptr <= rptr + ONE_P;
      end
      if (mark_set) begin
        mptr        <= rptr;
        mark_active <= 1'b1;
      end else if (mark_drop) begin
        mark_active <= 1'b0;
      end
    end
  end

  // Read pipeline: valid bits shift every cycle, data only follows a valid beat so o_front holds the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        data_pipe[k] <= '0;
      end
    end else begin
      vld_pipe[0] <= pop_ok;
      if (pop_ok) begin
        data_pipe[0] <= mem[rptr[FIFO_DEPTH_BIT-1:0]];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1] & ~pipe_clr;
        if (vld_pipe[k-1]) begin
          data_pipe[k] <= data_pipe[k-1];
        end
      end
    end
  end

  assign o_vld   = vld_pipe[RD_LAT-1];
  assign o_front = data_pipe[RD_LAT-1];

`ifdef REPLAY_SAMPLE_FIFO_ERR_FLAG_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (i_flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (i_push & o_full) begin
        ovf_q <= 1'b1;
      end
      if (i_pop & o_empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`else
  assign o_ovf = 1'b0;
  assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_replay_sample_fifo.sv
// Randomized bench for replay_sample_fifo against a queue-based model of live and replayable entries.
module tb_replay_sample_fifo;

  localparam int W      = 16;
  localparam int DB     = 4;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 2;
  localparam int AFULL  = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush, i_mark, i_mark_clr, i_rewind, i_push, i_pop;
  logic [W-1:0]  i_rear;
  logic [W-1:0]  o_front;
  logic          o_vld, o_full, o_empty, o_afull, o_ovf, o_udf;
  logic [DB:0]   o_count;

  replay_sample_fifo #(
    .FIFO_WIDTH(W), .FIFO_DEPTH_BIT(DB), .RD_LAT(RD_LAT), .AFULL_THRESH(AFULL)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_mark(i_mark), .i_mark_clr(i_mark_clr),
    .i_rewind(i_rewind), .i_push(i_push), .i_rear(i_rear), .i_pop(i_pop),
    .o_front(o_front), .o_vld(o_vld), .o_full(o_full), .o_empty(o_empty),
    .o_afull(o_afull), .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [W-1:0] data;
  } pend_t;

  // Model: live entries, entries popped since the mark, and read results still in flight.
  logic [W-1:0] live_q[$];
  logic [W-1:0] replay_q[$];
  pend_t        pend_q[$];
  logic         m_mark;
  logic         m_ovf, m_udf;
  int           cyc;
  int           test_count;
  int           fail_count;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, actual, expected);
    end
  endtask

  function automatic int occupancy();
    return m_mark ? (live_q.size() + replay_q.size()) : live_q.size();
  endfunction

  task automatic modelClear();
    live_q.delete();
    replay_q.delete();
    pend_q.delete();
    m_mark = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic checkState();
    logic         exp_vld;
    logic [W-1:0] exp_data;
    exp_vld  = 1'b0;
    exp_data = '0;
    foreach (pend_q[i]) begin
      if (pend_q[i].due == cyc) begin
        exp_vld  = 1'b1;
        exp_data = pend_q[i].data;
      end
    end
    checkOutput("o_vld", 32'(o_vld), 32'(exp_vld));
    if (exp_vld) checkOutput("o_front", 32'(o_front), 32'(exp_data));
    while (pend_q.size() > 0 && pend_q[0].due <= cyc) void'(pend_q.pop_front());
    checkOutput("o_count", 32'(o_count), 32'(live_q.size()));
    checkOutput("o_empty", 32'(o_empty), 32'(live_q.size() == 0));
    checkOutput("o_full", 32'(o_full), 32'(occupancy() == DEPTH));
    checkOutput("o_afull", 32'(o_afull), 32'(occupancy() >= AFULL));
    checkOutput("o_ovf", 32'(o_ovf), 32'(m_ovf));
    checkOutput("o_udf", 32'(o_udf), 32'(m_udf));
  endtask

  task automatic applyStimulus(input logic fl, input logic mk, input logic mc, input logic rw,
                               input logic ps, input logic [W-1:0] d, input logic pp);
    logic         full_now, empty_now, pop_ok, push_ok;
    logic [W-1:0] item;
    pend_t        p;
    @(negedge clk);
    checkState();
    i_flush = fl; i_mark = mk; i_mark_clr = mc; i_rewind = rw;
    i_push = ps; i_rear = d; i_pop = pp;
    full_now  = (occupancy() == DEPTH);
    empty_now = (live_q.size() == 0);
    if (fl) begin
      live_q.delete();
      replay_q.delete();
      pend_q.delete();
      m_mark = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
`ifdef REPLAY_SAMPLE_FIFO_ERR_FLAG_EN
      if (ps && full_now) m_ovf = 1'b1;
      if (pp && empty_now) m_udf = 1'b1;
`endif
      pop_ok  = pp && !empty_now && !rw;
      push_ok = ps && !full_now;
      item    = '0;
      if (pop_ok) item = live_q.pop_front();
      if (rw && m_mark) begin
        pend_q.delete();
        for (int i = replay_q.size() - 1; i >= 0; i--) live_q.push_front(replay_q[i]);
        replay_q.delete();
      end else if (mk) begin
        m_mark = 1'b1;
        replay_q.delete();
        if (pop_ok) replay_q.push_back(item);
      end else if (mc) begin
        m_mark = 1'b0;
        replay_q.delete();
      end else if (pop_ok && m_mark) begin
        replay_q.push_back(item);
      end
      if (push_ok) live_q.push_back(d);
      if (pop_ok) begin
        p.due  = cyc + RD_LAT;
        p.data = item;
        pend_q.push_back(p);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, W'($urandom_range(0, 65535)), 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    i_flush = 0; i_mark = 0; i_mark_clr = 0; i_rewind = 0; i_push = 0; i_pop = 0;
    modelClear();
    #1;
    checkOutput("rst_vld", 32'(o_vld), 32'd0);
    checkOutput("rst_front", 32'(o_front), 32'd0);
    checkOutput("rst_count", 32'(o_count), 32'd0);
    checkOutput("rst_empty", 32'(o_empty), 32'd1);
    checkOutput("rst_full", 32'(o_full), 32'd0);
    checkOutput("rst_afull", 32'(o_afull), 32'd0);
    checkOutput("rst_ovf", 32'(o_ovf), 32'd0);
    checkOutput("rst_udf", 32'(o_udf), 32'd0);
    @(negedge clk);
    checkOutput("rst_vld_hold", 32'(o_vld), 32'd0);
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int pp_bias;
    int ps_bias;
    test_count = 0;
    fail_count = 0;
    cyc = 0;
    rst = 1'b1;
    i_flush = 0; i_mark = 0; i_mark_clr = 0; i_rewind = 0;
    i_push = 0; i_rear = '0; i_pop = 0;
    modelClear();
    pulseReset();

    // Fill to full, then drain in order.
    for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 0, 0, 1, W'(i), 0);
    applyStimulus(0, 0, 0, 0, 1, 16'hdead, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 0, '0, 1);
    idle(4);

    // Mark, pop four, overfill against the mark, then rewind and replay everything.
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 0, 1, W'(i), 0);
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 1, W'(16'h100 + i), 0);
    applyStimulus(0, 0, 0, 1, 0, '0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 0, '0, 1);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);
    idle(3);

    // Rewind the cycle after a pop suppresses that pop's result.
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, W'(16'h200 + i), 0);
    applyStimulus(0, 1, 0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    idle(4);
    applyStimulus(0, 0, 1, 0, 0, '0, 0);

    // Simultaneous push and pop at both boundaries.
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, 1, W'(16'h300 + i), 0);
    applyStimulus(0, 0, 0, 0, 1, 16'hbeef, 1);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0abc, 1);
    idle(4);

    // Push into a full FIFO and pop an empty one, then flush the error state.
    applyStimulus(1, 0, 0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 1, W'(16'h400 + i), 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 1, 16'h5555, 0);
    idle(2);

    // Reset while reads are in flight.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, W'(16'h500 + i), 0);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, 0, 0, '0, 1);
    pulseReset();
    idle(4);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 24; ph++) begin
      ps_bias = (ph % 2 == 0) ? 80 : 35;
      pp_bias = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 120; i++) begin
        applyStimulus($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < 5,
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 6,
                      $urandom_range(0, 99) < ps_bias,
                      W'($urandom_range(0, 65535)),
                      $urandom_range(0, 99) < pp_bias);
      end
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
